// File: rtl/iir_coeff_loader.sv
// Coefficient-bank loader for the IIR cascade: streams N words into the x/y
// slots, reads every slot back against a shadow copy, and reports done/error.
module iir_coeff_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NUM_X  = 6,
  parameter int X_BASE = 0,
  parameter int NUM_Y  = 3,
  parameter int Y_BASE = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int N     = NUM_X + NUM_Y;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE, S_ERR} state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W-1:0]           rd_idx_q, rd_idx_d;
  logic                       rd_all_q, rd_all_d;
  logic [IDX_W-1:0]           cmp_idx_q, cmp_idx_d;
  logic                       rd_pend_q, rd_pend_d;
  logic [N-1:0][DATA_W-1:0]   shadow_q, shadow_d;
  logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]          mem_wdata_q, mem_wdata_d;
  logic                       mem_we_q, mem_we_d;
  logic                       mem_re_q, mem_re_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic [ADDR_W-1:0]          err_addr_q, err_addr_d;

  // Word index -> bank address: x slots first, then y slots.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [IDX_W-1:0] i);
    logic [ADDR_W-1:0] a;
    if (i < IDX_W'(NUM_X)) a = ADDR_W'(X_BASE) + ADDR_W'(i);
    else                   a = ADDR_W'(Y_BASE) + ADDR_W'(i) - ADDR_W'(NUM_X);
    return a;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    rd_all_d    = rd_all_q;
    cmp_idx_d   = cmp_idx_q;
    rd_pend_d   = 1'b0;
    shadow_d    = shadow_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    done_d      = done_q;
    error_d     = error_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = '0;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          shadow_d[idx_q] = s_data;
          mem_we_d        = 1'b1;
          mem_addr_d      = slot_addr(idx_q);
          mem_wdata_d     = s_data;
          idx_d           = idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_d   = S_VERIFY;
            idx_d     = '0;
            rd_idx_d  = '0;
            rd_all_d  = 1'b0;
            cmp_idx_d = '0;
          end
        end
      end
      S_VERIFY: begin
        // Reads start the cycle after the final write, since the port is shared.
        if (!rd_all_q) begin
          mem_re_d   = 1'b1;
          mem_addr_d = slot_addr(rd_idx_q);
          rd_idx_d   = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST) rd_all_d = 1'b1;
        end
        rd_pend_d = mem_re_q;
        if (rd_pend_q) begin
          if (mem_rdata != shadow_q[cmp_idx_q]) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_addr_d = slot_addr(cmp_idx_q);
            mem_re_d   = 1'b0;
            mem_addr_d = mem_addr_q;
            rd_pend_d  = 1'b0;
          end else if (cmp_idx_q == LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            cmp_idx_d = cmp_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      rd_all_q    <= 1'b0;
      cmp_idx_q   <= '0;
      rd_pend_q   <= 1'b0;
      shadow_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      rd_all_q    <= rd_all_d;
      cmp_idx_q   <= cmp_idx_d;
      rd_pend_q   <= rd_pend_d;
      shadow_q    <= shadow_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign s_ready   = (state_q == S_LOAD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Bench for iir_coeff_loader: a default-parameter unit and a small override
// unit, each with a bank model and a timeline-level reference model.
module tb_iir_coeff_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start [2];
  logic        s_valid [2];
  logic [15:0] s_data [2];
  logic        s_ready [2];
  logic [7:0]  mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic        mem_we [2];
  logic        mem_re [2];
  logic [15:0] mem_rdata [2];
  logic        busy [2];
  logic        done [2];
  logic        error [2];
  logic [7:0]  err_addr [2];

  logic [15:0] mem [2][256];
  logic        corrupt_en [2];
  logic [7:0]  corrupt_addr [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  int cfg_nx [2] = '{6, 2};
  int cfg_xb [2] = '{0, 0};
  int cfg_ny [2] = '{3, 1};
  int cfg_yb [2] = '{15, 8};

  always #5 clk = ~clk;

  iir_coeff_loader dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .s_valid(s_valid[0]),
    .s_data(s_data[0]), .s_ready(s_ready[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .mem_re(mem_re[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]), .err_addr(err_addr[0]));

  iir_coeff_loader #(.NUM_X(2), .Y_BASE(8), .NUM_Y(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .s_valid(s_valid[1]),
    .s_data(s_data[1]), .s_ready(s_ready[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .mem_re(mem_re[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]), .err_addr(err_addr[1]));

  // Bank model: one-cycle read latency, optional corruption of one address.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_we[u] === 1'b1) mem[u][mem_addr[u]] <= mem_wdata[u];
      if (mem_re[u] === 1'b1)
        mem_rdata[u] <= (corrupt_en[u] && mem_addr[u] == corrupt_addr[u]) ? 16'h0000
                                                                          : mem[u][mem_addr[u]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_LOAD = 1, P_VER = 2, P_DONE = 3, P_ERR = 4;
  int          m_ph [2] = '{P_IDLE, P_IDLE};
  int          m_nacc [2];
  int          m_vt [2];
  logic [15:0] m_sh [2][16];
  logic        e_we [2] = '{0, 0};
  logic        e_re [2] = '{0, 0};
  logic        e_done [2] = '{0, 0};
  logic        e_err [2] = '{0, 0};
  logic [7:0]  e_addr [2] = '{0, 0};
  logic [7:0]  e_erraddr [2] = '{0, 0};
  logic [15:0] e_wdata [2] = '{0, 0};

  logic [23:0] wlog0 [$];
  logic [23:0] wlog1 [$];
  int          rcnt0 = 0;

  function automatic int slot(input int u, input int i);
    return (i < cfg_nx[u]) ? cfg_xb[u] + i : cfg_yb[u] + i - cfg_nx[u];
  endfunction

  task automatic advance(input int u);
    int n, idx;
    logic [15:0] got;
    bit settled;
    n = cfg_nx[u] + cfg_ny[u];
    if (reset) begin
      m_ph[u] = P_IDLE; m_nacc[u] = 0; m_vt[u] = 0;
      e_we[u] = 0; e_re[u] = 0; e_done[u] = 0; e_err[u] = 0;
      e_addr[u] = 0; e_erraddr[u] = 0; e_wdata[u] = 0;
      return;
    end
    e_we[u] = 0;
    e_re[u] = 0;
    case (m_ph[u])
      P_IDLE, P_DONE, P_ERR:
        if (start[u]) begin
          m_ph[u] = P_LOAD; m_nacc[u] = 0;
          e_done[u] = 0; e_err[u] = 0; e_erraddr[u] = 0;
        end
      P_LOAD:
        if (s_valid[u]) begin
          m_sh[u][m_nacc[u]] = s_data[u];
          e_we[u] = 1; e_addr[u] = 8'(slot(u, m_nacc[u])); e_wdata[u] = s_data[u];
          m_nacc[u]++;
          if (m_nacc[u] == n) begin m_ph[u] = P_VER; m_vt[u] = 0; end
        end
      P_VER: begin
        // vt counts cycles since the final write; read k lands at vt=k+1, compared at vt=k+2.
        settled = 0;
        if (m_vt[u] >= 2) begin
          idx = m_vt[u] - 2;
          got = (corrupt_en[u] && 8'(slot(u, idx)) == corrupt_addr[u]) ? 16'h0000 : m_sh[u][idx];
          if (got != m_sh[u][idx]) begin
            m_ph[u] = P_ERR; e_err[u] = 1; e_erraddr[u] = 8'(slot(u, idx)); settled = 1;
          end else if (idx == n - 1) begin
            m_ph[u] = P_DONE; e_done[u] = 1; settled = 1;
          end
        end
        if (!settled) begin
          m_vt[u]++;
          if (m_vt[u] <= n) begin e_re[u] = 1; e_addr[u] = 8'(slot(u, m_vt[u] - 1)); end
        end
      end
      default: m_ph[u] = P_IDLE;
    endcase
  endtask

  // Compare every cycle on the falling edge, then step the model with the
  // inputs the DUT will sample on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (chk_on) begin
          check("s_ready", 32'(s_ready[u]), 32'(m_ph[u] == P_LOAD));
          check("busy", 32'(busy[u]), 32'(m_ph[u] == P_LOAD || m_ph[u] == P_VER));
          check("done", 32'(done[u]), 32'(e_done[u]));
          check("error", 32'(error[u]), 32'(e_err[u]));
          check("err_addr", 32'(err_addr[u]), 32'(e_erraddr[u]));
          check("mem_we", 32'(mem_we[u]), 32'(e_we[u]));
          check("mem_re", 32'(mem_re[u]), 32'(e_re[u]));
          if (e_we[u] || e_re[u]) check("mem_addr", 32'(mem_addr[u]), 32'(e_addr[u]));
          if (e_we[u]) check("mem_wdata", 32'(mem_wdata[u]), 32'(e_wdata[u]));
        end
        if (mem_we[u] === 1'b1) begin
          if (u == 0) wlog0.push_back({mem_addr[u], mem_wdata[u]});
          else        wlog1.push_back({mem_addr[u], mem_wdata[u]});
        end
        if (u == 0 && mem_re[u] === 1'b1) rcnt0++;
        advance(u);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] word(input int u, input int k);
    logic [15:0] w1 [3] = '{16'hAAAA, 16'h5555, 16'h1234};
    if (u == 0) return 16'(16'h0800 * (k + 1));
    return w1[k];
  endfunction

  task automatic do_start(input int u);
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
  endtask

  task automatic stream(input int u, input int first, input int cnt, input bit gap);
    for (int k = first; k < first + cnt; k++) begin
      s_valid[u] = 1'b1;
      s_data[u]  = word(u, k);
      tick();
      if (gap) begin
        s_valid[u] = 1'b0;
        s_data[u]  = 16'hDEAD;
        tick();
      end
    end
    s_valid[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    int c = 0;
    while (busy[u] && c < 100) begin tick(); c++; end
    check("idle_timeout", 32'(busy[u]), 32'd0);
  endtask

  task automatic check_wlog0(input string name);
    int a [9] = '{0, 1, 2, 3, 4, 5, 15, 16, 17};
    check({name, "_nwr"}, 32'(wlog0.size()), 32'd9);
    for (int k = 0; k < 9 && k < wlog0.size(); k++) begin
      check({name, "_waddr"}, 32'(wlog0[k][23:16]), 32'(a[k]));
      check({name, "_wdata"}, 32'(wlog0[k][15:0]), 32'(16'h0800 * (k + 1)));
    end
  endtask

  task automatic check_zero0(input string name);
    check({name, "_ready"}, 32'(s_ready[0]), 0);
    check({name, "_we"}, 32'(mem_we[0]), 0);
    check({name, "_re"}, 32'(mem_re[0]), 0);
    check({name, "_busy"}, 32'(busy[0]), 0);
    check({name, "_done"}, 32'(done[0]), 0);
    check({name, "_error"}, 32'(error[0]), 0);
    check({name, "_addr"}, 32'(mem_addr[0]), 0);
    check({name, "_wdata"}, 32'(mem_wdata[0]), 0);
    check({name, "_erraddr"}, 32'(err_addr[0]), 0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      start[u] = 0; s_valid[u] = 0; s_data[u] = 0;
      corrupt_en[u] = 0; corrupt_addr[u] = 0;
    end
    reset = 1'b1;
    tick(); tick();
    check_zero0("reset");
    reset = 1'b0;
    chk_on = 1'b1;
    tick();

    // 1: continuous stream, exact cycle budget to done
    wlog0.delete();
    do_start(0);
    stream(0, 0, 9, 0);
    repeat (10) tick();
    check("t1_busy_late", 32'(busy[0]), 1);
    check("t1_done_early", 32'(done[0]), 0);
    tick();
    check("t1_done", 32'(done[0]), 1);
    check("t1_error", 32'(error[0]), 0);
    check_wlog0("t1");

    // 2: gapped stream
    wlog0.delete();
    do_start(0);
    check("t2_done_clr", 32'(done[0]), 0);
    stream(0, 0, 9, 1);
    wait_idle(0);
    check("t2_done", 32'(done[0]), 1);
    check_wlog0("t2");

    // 3: corrupted readback at addr 16
    corrupt_en[0] = 1'b1; corrupt_addr[0] = 8'd16;
    rcnt0 = 0;
    do_start(0);
    stream(0, 0, 9, 0);
    wait_idle(0);
    tick();
    check("t3_error", 32'(error[0]), 1);
    check("t3_err_addr", 32'(err_addr[0]), 32'd16);
    check("t3_done", 32'(done[0]), 0);
    check("t3_nreads", 32'(rcnt0), 32'd9);
    corrupt_en[0] = 1'b0;

    // 4: reset mid-load
    do_start(0);
    stream(0, 0, 4, 0);
    reset = 1'b1;
    tick();
    check_zero0("t4_rst");
    reset = 1'b0;
    tick();
    wlog0.delete();
    do_start(0);
    stream(0, 0, 1, 0);
    check("t4_we", 32'(mem_we[0]), 1);
    check("t4_addr", 32'(mem_addr[0]), 0);
    check("t4_wdata", 32'(mem_wdata[0]), 32'h0800);
    stream(0, 1, 8, 0);
    wait_idle(0);
    check("t4_done", 32'(done[0]), 1);

    // 5: start while busy is ignored; start from DONE restarts at addr 0
    wlog0.delete();
    do_start(0);
    stream(0, 0, 3, 0);
    start[0] = 1'b1;
    stream(0, 3, 1, 0);
    start[0] = 1'b0;
    stream(0, 4, 5, 0);
    wait_idle(0);
    check("t5_done", 32'(done[0]), 1);
    check_wlog0("t5");
    do_start(0);
    check("t5_done_clr", 32'(done[0]), 0);
    check("t5_busy", 32'(busy[0]), 1);
    stream(0, 0, 1, 0);
    check("t5_addr0", 32'(mem_addr[0]), 0);
    stream(0, 1, 8, 0);
    wait_idle(0);

    // 6: override-parameter unit
    wlog1.delete();
    do_start(1);
    stream(1, 0, 3, 0);
    wait_idle(1);
    tick();
    check("t6_done", 32'(done[1]), 1);
    check("t6_nwr", 32'(wlog1.size()), 32'd3);
    if (wlog1.size() == 3) begin
      check("t6_a0", 32'(wlog1[0]), 32'h00AAAA);
      check("t6_a1", 32'(wlog1[1]), 32'h015555);
      check("t6_a2", 32'(wlog1[2]), 32'h081234);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
